bin2bcd_seq: RTL

Sequential, parametrised binary-to-BCD converter using the iterative shift-and-add-3 (double-dabble) method.
- Processes one input bit per clock.
- Replaces wide combinational divide/modulo conversion in display and reporting paths.
- Valid/ready handshake on both sides.
- Flags values that do not fit in the configured digit count.

---
 rtl/bin2bcd_pkg.sv | 14 +
 rtl/bin2bcd_seq_bcd_digit_adj.sv | 12 +
 rtl/bin2bcd_seq.sv | 115 +++++++++++
 3 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential double-dabble binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int         BCD_W      = 4;
    localparam logic [3:0] ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bin2bcd_seq_bcd_digit_adj.sv
// One-digit double-dabble correction: digits of 5 or more get +3 before the shift.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [BCD_W-1:0] d,
    output logic [BCD_W-1:0] q
);

    // Largest input is 9, so the result never exceeds 12 and fits the digit.
    assign q = (d >= ADJ_THRESH) ? (d + ADJ_ADD) : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock, valid/ready on both sides.
// Optional macro BIN2BCD_SIGNED_EN: two's-complement input, magnitude converted, sign on out_neg.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_ovf
`ifdef BIN2BCD_SIGNED_EN
    ,
    output logic                  out_neg
`endif
);

    localparam int CNT_W = $clog2(BIN_W);
    localparam int ACC_W = BCD_W * DIGITS;

    state_t             state_reg, state_next;
    logic [BIN_W-1:0]   bin_sr_reg;
    logic [ACC_W-1:0]   bcd_acc_reg;
    logic [ACC_W-1:0]   bcd_adj;
    logic [CNT_W-1:0]   cnt_reg;
    logic               ovf_reg;
    logic [BIN_W-1:0]   load_val;
    logic               accept;
    logic               take;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_digit_adj u_adj (
                .d (bcd_acc_reg[gi*BCD_W +: BCD_W]),
                .q (bcd_adj[gi*BCD_W +: BCD_W])
            );
        end
    endgenerate

`ifdef BIN2BCD_SIGNED_EN
    logic neg_reg;

    // Negating the most negative value wraps to itself, which is its correct unsigned magnitude.
    assign load_val = in_bin[BIN_W-1] ? (-in_bin) : in_bin;
    assign out_neg  = neg_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_reg <= 1'b0;
        end else if (accept) begin
            neg_reg <= in_bin[BIN_W-1];
        end
    end
`else
    assign load_val = in_bin;
`endif

    assign accept = in_valid && in_ready;
    assign take   = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = CONV;
            CONV:    if (cnt_reg == '0) state_next = DONE;
            DONE:    if (take) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == IDLE);
        out_valid = (state_reg == DONE);
    end

    // Whatever leaves the top digit is a carry into a digit we do not keep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_sr_reg  <= '0;
            bcd_acc_reg <= '0;
            cnt_reg     <= '0;
            ovf_reg     <= 1'b0;
        end else if (accept) begin
            bin_sr_reg  <= load_val;
            bcd_acc_reg <= '0;
            cnt_reg     <= CNT_W'(BIN_W - 1);
            ovf_reg     <= 1'b0;
        end else if (state_reg == CONV) begin
            {bcd_acc_reg, bin_sr_reg} <= {bcd_adj[ACC_W-2:0], bin_sr_reg, 1'b0};
            ovf_reg                   <= ovf_reg | bcd_adj[ACC_W-1];
            if (cnt_reg != '0) begin
                cnt_reg <= cnt_reg - CNT_W'(1);
            end
        end
    end

    assign out_bcd = bcd_acc_reg;
    assign out_ovf = ovf_reg;

endmodule
